multi_alu_pipe: RTL and testbench
=================================

Name: multi_alu_pipe

Overview:
- Parametrised successor to the dual 4-bit ALU user-project block: NCH independent WIDTH-bit ALU channels behind one valid/ready handshake.
- Two-stage pipeline: operand register, then compute/result register.
- Adds a per-channel accumulate mode, sticky overflow flags and a completed-transaction counter.
- Sits inside the user project area, fed from mprj_io inputs or a host wrapper; results drive mprj_io outputs.

Parameters:
- WIDTH, 4, operand width per channel (2..16).
- NCH, 2, number of ALU channels (1..8).
- CNT_W, 16, width of the transaction counter.

Ports:
- clock  input  1  system clock; all state on posedge.
- resetb  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle.
- in_a  input  NCH*WIDTH  operand A; channel k uses bits [k*WIDTH +: WIDTH].
- in_b  input  NCH*WIDTH  operand B, same packing as in_a.
- in_op  input  NCH*2  per-channel opcode: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- in_acc  input  NCH  per-channel accumulate mode; when 1, the channel's accumulator replaces A.
- acc_clr  input  1  single-cycle pulse; clears all accumulators.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  downstream accepts the result.
- out_res  output  NCH*(WIDTH+1)  per-channel result; MSB is carry/borrow, [WIDTH-1:0] is the value.
- ovf_sticky  output  NCH  per-channel sticky carry/borrow flag.
- flags_clr  input  1  single-cycle pulse; clears ovf_sticky.
- txn_count  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (resetb=0, asynchronous):
  - s1_valid=0, out_valid=0, out_res=0, ovf_sticky=0, txn_count=0, all accumulators=0.
  - in_ready returns to 1 on the first clock after reset release.
- Stage 1 (operand register):
  - Captures in_a, in_b, in_op and in_acc when in_valid && in_ready.
  - in_ready = !s1_valid || adv, where adv = !out_valid || out_ready.
- Stage 2 (compute/result register):
  - When s1_valid && adv, computes each channel from the stage-1 operands and the current accumulator, loads out_res, sets out_valid=1.
  - When adv holds without s1_valid, out_valid goes to 0.
- Latency and throughput:
  - Two cycles from the input handshake to out_valid.
  - One bundle per cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_res and out_valid hold stable.
  - Stage 1 holds; in_ready is 0 if s1_valid.
  - No data is dropped or duplicated.
- Operand A: the accumulator if in_acc[k]=1, otherwise in_a. Operand B is always in_b.
- Arithmetic, computed at WIDTH+1 bits, zero-extended:
  - ADD: A+B; MSB is carry.
  - SUB: A-B; MSB is borrow (1 when A<B); low bits wrap mod 2^WIDTH.
  - AND / XOR: bitwise; MSB is 0.
- Accumulator k:
  - On each stage-2 load with in_acc[k]=1, set to out_res[k][WIDTH-1:0].
  - Unchanged for non-accumulate operations.
- acc_clr:
  - Clears all accumulators on the clock it is asserted.
  - If a stage-2 load happens in the same cycle, that operation uses 0 as the accumulator value, and the accumulator is then written with the new result (the write wins over the clear).
- ovf_sticky[k]:
  - Set on a stage-2 load whose ADD carry or SUB borrow is 1.
  - Cleared by flags_clr; a simultaneous set wins.
- txn_count: increments on out_valid && out_ready; wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight bundles are discarded; no output handshake follows reset release until new input is accepted.

Optional Feature:
- Macro: MULTI_ALU_SAT_EN.
- Defined:
  - ADD saturates to all-ones and SUB floors to 0.
  - Result MSB becomes a "saturated" indicator rather than carry/borrow.
  - ovf_sticky is set on saturation.
  - The accumulator stores the saturated value.
- Undefined: wrap-around arithmetic as described in Behaviour; no saturation logic is synthesised.

Test Plan (WIDTH=4, NCH=2):
- Reset then ch0 A=9, B=9, ADD and ch1 A=0, B=0, ADD, out_ready=1 -> 2 cycles later out_res ch0=5'b10010, ch1=5'b00000; ovf_sticky=2'b01; txn_count=1.
- ch0 SUB A=3, B=5 -> 5'b11110, ovf_sticky[0]=1. Then flags_clr -> ovf_sticky[0]=0. Then ch1 XOR A=0xA, B=0x6 -> 5'b01100.
- ch0 in_acc=1, B=7, ADD for three back-to-back beats -> results 00111, 01110, 10101; accumulator ends at 4'b0101. Then acc_clr with the next ADD B=2 -> result 00010.
- out_ready=0 for 5 cycles while streaming 4 bundles -> out_res stable and in_ready=0 after 2 bundles are accepted. Release out_ready -> all 4 results in order; txn_count advances by 4.
- Assert resetb=0 with both stages full -> all outputs zero immediately (asynchronously); no spurious out_valid after release.
- With MULTI_ALU_SAT_EN: ADD 9+9 -> 5'b11111; SUB 3-5 -> 5'b10000; ovf_sticky set.

Source files
------------

// File: rtl/multi_alu_pipe.sv
// multi_alu_pipe: NCH independent WIDTH-bit ALU channels behind a single valid/ready
// handshake. There are two pipeline stages: an operand register, then a compute/result register.
// Each channel has an accumulate mode and a sticky carry/borrow flag. A counter tracks
// completed output handshakes.
// Optional feature: define MULTI_ALU_SAT_EN for saturating ADD/SUB. In that build the result MSB
// flags saturation.
module multi_alu_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*WIDTH-1:0]     in_a,
  input  logic [NCH*WIDTH-1:0]     in_b,
  input  logic [NCH*2-1:0]         in_op,
  input  logic [NCH-1:0]           in_acc,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*(WIDTH+1)-1:0] out_res,
  output logic [NCH-1:0]           ovf_sticky,
  input  logic                     flags_clr,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int unsigned RW = WIDTH + 1;

  logic                 r_rst_done;
  logic                 r_s1_valid;
  logic [NCH*WIDTH-1:0] r_s1_a;
  logic [NCH*WIDTH-1:0] r_s1_b;
  logic [NCH*2-1:0]     r_s1_op;
  logic [NCH-1:0]       r_s1_acc;
  logic                 r_out_valid;
  logic [NCH*RW-1:0]    r_out_res;
  logic [NCH-1:0]       r_ovf;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_acc [NCH];

  logic                 w_adv;
  logic                 w_s1_load;
  logic                 w_s2_load;
  logic [NCH*RW-1:0]    w_res;
  logic [NCH-1:0]       w_ovf_set;

  // One channel's ALU. The result MSB is carry/borrow, or the saturation flag in the
  // saturating build.
  function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [1:0]       op);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] res;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    case (op)
      2'b00:   res = sum;
      2'b01:   res = diff;
      2'b10:   res = {1'b0, a & b};
      default: res = {1'b0, a ^ b};
    endcase
`ifdef MULTI_ALU_SAT_EN
    if (op == 2'b00 && sum[WIDTH]) res = {1'b1, {WIDTH{1'b1}}};
    if (op == 2'b01 && diff[WIDTH]) res = {1'b1, {WIDTH{1'b0}}};
`endif
    return res;
  endfunction

  assign w_adv     = !r_out_valid || out_ready;
  // Hold off input until the first clock after reset release.
  assign in_ready  = r_rst_done && (!r_s1_valid || w_adv);
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_s1_valid && w_adv;

  assign out_valid  = r_out_valid;
  assign out_res    = r_out_res;
  assign ovf_sticky = r_ovf;
  assign txn_count  = r_cnt;

  // Per-channel compute. A clear arriving with a load makes the accumulator read as zero.
  always_comb begin
    w_res     = '0;
    w_ovf_set = '0;
    for (int k = 0; k < NCH; k++) begin
      w_res[k*RW +: RW] = alu_op(r_s1_acc[k] ? (acc_clr ? '0 : r_acc[k])
                                             : r_s1_a[k*WIDTH +: WIDTH],
                                 r_s1_b[k*WIDTH +: WIDTH],
                                 r_s1_op[k*2 +: 2]);
      w_ovf_set[k] = w_res[k*RW + WIDTH];
    end
  end

  // Reset-release tracker that gates in_ready.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_rst_done <= 1'b0;
    else         r_rst_done <= 1'b1;
  end

  // Stage 1: operand register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_acc   <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_load) begin
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_op  <= in_op;
        r_s1_acc <= in_acc;
      end
    end
  end

  // Stage 2: result register. It holds while the consumer stalls.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_res <= w_res;
    end
  end

  // Accumulators. A result write takes priority over a simultaneous clear.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_s2_load && r_s1_acc[k]) r_acc[k] <= w_res[k*RW +: WIDTH];
        else if (acc_clr)             r_acc[k] <= '0;
      end
    end
  end

  // Sticky overflow flags. A set takes priority over a simultaneous clear.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_ovf <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_s2_load && w_ovf_set[k]) r_ovf[k] <= 1'b1;
        else if (flags_clr)            r_ovf[k] <= 1'b0;
      end
    end
  end

  // Completed-handshake counter. It wraps naturally.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)                       r_cnt <= '0;
    else if (r_out_valid && out_ready) r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_multi_alu_pipe.sv
// Directed self-checking bench for multi_alu_pipe (WIDTH=4, NCH=2).
// out_res packing is {ch1[4:0], ch0[4:0]}.
module tb_multi_alu_pipe;

  logic       clock;
  logic       resetb;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic [1:0] in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_res;
  logic [1:0] ovf_sticky;
  logic       flags_clr;
  logic [15:0] txn_count;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULTI_ALU_SAT_EN
  localparam logic [9:0] EAdd99 = 10'h01F;
  localparam logic [9:0] ESub35 = 10'h010;
  localparam logic [9:0] EAcc3  = 10'h01F;
  localparam logic [9:0] EAcc0  = 10'h00F;
`else
  localparam logic [9:0] EAdd99 = 10'h012;
  localparam logic [9:0] ESub35 = 10'h01E;
  localparam logic [9:0] EAcc3  = 10'h015;
  localparam logic [9:0] EAcc0  = 10'h005;
`endif

  multi_alu_pipe #(.WIDTH(4), .NCH(2), .CNT_W(16)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .ovf_sticky (ovf_sticky),
    .flags_clr  (flags_clr),
    .txn_count  (txn_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bundle for a single accepting cycle, then drop in_valid.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [1:0] accm);
    in_a = a; in_b = b; in_op = op; in_acc = accm; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $error("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    resetb = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0;
    acc_clr = 0; out_ready = 1; flags_clr = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_cnt", txn_count, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clock);
    resetb = 1'b1;
    cyc();
    check("ready_after_release", in_ready, 1);

    // ch0 9+9 ADD, ch1 0+0 ADD
    issue(8'h09, 8'h09, 4'b0000, 2'b00);
    check("lat1_not_yet", out_valid, 0);
    cyc();
    check("add99_valid", out_valid, 1);
    check("add99_res", out_res, EAdd99);
    check("add99_ovf", ovf_sticky, 2'b01);
    cyc();
    check("add99_cnt", txn_count, 1);
    check("add99_drain", out_valid, 0);

    // ch0 SUB 3-5
    issue(8'h03, 8'h05, 4'b0001, 2'b00);
    cyc();
    check("sub35_res", out_res, ESub35);
    check("sub35_ovf", ovf_sticky, 2'b01);
    cyc();
    flags_clr = 1'b1;
    cyc();
    flags_clr = 1'b0;
    check("flags_clr", ovf_sticky, 2'b00);

    // ch1 XOR A^6, ch0 AND 0&0
    issue(8'hA0, 8'h60, 4'b1110, 2'b00);
    cyc();
    check("xor_res", out_res, 10'h180);
    check("xor_ovf", ovf_sticky, 2'b00);
    cyc();
    check("cnt3", txn_count, 3);

    // ch0 accumulate +7, three back-to-back beats
    in_a = 0; in_b = 8'h07; in_op = 0; in_acc = 2'b01; in_valid = 1'b1;
    cyc();
    cyc();
    check("acc_beat1", out_res, 10'h007);
    cyc();
    in_valid = 1'b0;
    check("acc_beat2", out_res, 10'h00E);
    cyc();
    check("acc_beat3", out_res, EAcc3);
    check("acc_ovf", ovf_sticky, 2'b01);
    cyc();
    // Reading the accumulator with +0 shows its final value.
    issue(8'h00, 8'h00, 4'b0000, 2'b01);
    cyc();
    check("acc_final", out_res, EAcc0);
    cyc();
    // Clear arriving with the load: the operation sees 0 and the result is still written.
    issue(8'h00, 8'h02, 4'b0000, 2'b01);
    acc_clr = 1'b1;
    cyc();
    acc_clr = 1'b0;
    check("acc_clr_res", out_res, 10'h002);
    cyc();
    issue(8'h00, 8'h01, 4'b0000, 2'b01);
    cyc();
    check("acc_after_clr", out_res, 10'h003);
    cyc();
    check("cnt9", txn_count, 9);

    // Backpressure: four bundles, out_ready low for five edges
    out_ready = 1'b0;
    in_a = 8'h81; in_b = 0; in_op = 0; in_acc = 0; in_valid = 1'b1;
    cyc();
    check("bp_ready_b1", in_ready, 1);
    in_a = 8'h92;
    cyc();
    check("bp_ready_full", in_ready, 0);
    check("bp_hold_e2", out_res, 10'h101);
    in_a = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_hold_res", out_res, 10'h101);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    check("bp_cnt_stalled", txn_count, 9);
    out_ready = 1'b1;
    cyc();
    check("bp_out_b1", out_res, 10'h122);
    in_a = 8'hB4;
    cyc();
    in_valid = 1'b0;
    check("bp_out_b2", out_res, 10'h143);
    cyc();
    check("bp_out_b3", out_res, 10'h164);
    cyc();
    check("bp_drain", out_valid, 0);
    check("bp_cnt", txn_count, 13);

    // Reset with both stages full
    out_ready = 1'b0;
    in_a = 8'h11; in_b = 8'h11; in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    #2;
    resetb = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_res", out_res, 0);
    check("arst_ovf", ovf_sticky, 0);
    check("arst_cnt", txn_count, 0);
    check("arst_ready", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clock);
    resetb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_no_valid", out_valid, 0);
    end
    check("post_rst_cnt", txn_count, 0);
    // Accumulators were cleared by reset.
    issue(8'h00, 8'h03, 4'b0000, 2'b01);
    cyc();
    check("post_rst_acc", out_res, 10'h003);
    cyc();
    check("post_rst_cnt1", txn_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
